// File: rtl/ifu_prefetch_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack side, branch redirect and the
// valid/ready instruction port toward the core. The fetch unit is the master.
interface ifu_prefetch_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/ifu_prefetch.sv
// Sequential instruction prefetcher with a DEPTH-entry FIFO and redirect flush.
// Define IFU_BYPASS_EN to forward a kept ack straight to the core when the FIFO is empty.
module ifu_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic           clk,
  input  logic           reset,
  ifu_prefetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

  state_t      r_state;
  logic        r_req;
  logic [63:0] r_addr;
  logic [63:0] r_fetch_pc;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [31:0] r_mem_inst [DEPTH];
  logic [63:0] r_mem_pc   [DEPTH];

  logic          w_fifo_valid;
  logic          w_keep;
  logic          w_bypass;
  logic          w_fifo_pop;
  logic          w_push;
  logic [CW-1:0] w_occ_next;
  logic          w_room;
  logic [63:0]   w_target;
  logic [63:0]   w_pc_inc;

  assign w_fifo_valid = (r_count != '0);
  assign w_keep       = (r_state == S_WAIT) && bus.imem_ack && !bus.redirect;
  assign w_fifo_pop   = w_fifo_valid && bus.inst_ready && !bus.redirect;

`ifdef IFU_BYPASS_EN
  // Empty FIFO: the returning word goes straight out, and is only stored if the core stalls.
  assign w_bypass       = w_keep && !w_fifo_valid;
  assign bus.inst_valid = w_fifo_valid || w_bypass;
  assign bus.inst       = w_bypass ? bus.imem_rdata : (w_fifo_valid ? r_mem_inst[r_rptr] : '0);
  assign bus.inst_pc    = w_bypass ? bus.imem_addr  : (w_fifo_valid ? r_mem_pc[r_rptr]   : '0);
`else
  assign w_bypass       = 1'b0;
  assign bus.inst_valid = w_fifo_valid;
  assign bus.inst       = w_fifo_valid ? r_mem_inst[r_rptr] : '0;
  assign bus.inst_pc    = w_fifo_valid ? r_mem_pc[r_rptr]   : '0;
`endif

  assign w_push     = w_keep && !(w_bypass && bus.inst_ready);
  assign w_occ_next = r_count + CW'(w_push) - CW'(w_fifo_pop);
  // A new request reserves one slot, so it may only issue while the FIFO has a spare entry.
  assign w_room     = (w_occ_next < CW'(DEPTH));
  assign w_target   = bus.redirect_pc & ~64'd3;
  assign w_pc_inc   = r_fetch_pc + 64'd4;

  assign bus.imem_req  = r_req;
  assign bus.imem_addr = r_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
      r_fetch_pc <= RESET_PC;
    end else if (bus.redirect) begin
      r_fetch_pc <= w_target;
      case (r_state)
        S_WAIT: begin
          if (bus.imem_ack) begin
            r_state <= S_WAIT;
            r_req   <= 1'b1;
            r_addr  <= w_target;
          end else begin
            r_state <= S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (bus.imem_ack) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
          end
        end
        default: begin
          // Bus is free and the FIFO is flushed, so the target request goes out next cycle.
          r_state <= S_WAIT;
          r_req   <= 1'b1;
          r_addr  <= w_target;
        end
      endcase
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_room) begin
            r_state <= S_WAIT;
            r_req   <= 1'b1;
            r_addr  <= r_fetch_pc;
          end
        end
        S_WAIT: begin
          if (bus.imem_ack) begin
            r_fetch_pc <= w_pc_inc;
            if (w_room) begin
              r_addr <= w_pc_inc;
            end else begin
              r_state <= S_IDLE;
              r_req   <= 1'b0;
            end
          end
        end
        default: begin
          if (bus.imem_ack) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (bus.redirect) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)     r_wptr <= r_wptr + AW'(1);
      if (w_fifo_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= w_occ_next;
    end
  end

  // Storage has no reset; the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_inst[r_wptr] <= bus.imem_rdata;
      r_mem_pc[r_wptr]   <= bus.imem_addr;
    end
  end
endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: variable-latency memory responder, stream-model scoreboard,
// directed reset/stall/redirect cases followed by a randomized run.
module tb_ifu_prefetch;
  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;
`ifdef IFU_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  ifu_prefetch_if bus();

  ifu_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int epoch = 0;
  int ack_cnt = 0;
  int delivered = 0;
  logic [95:0] exp_q[$];
  logic [63:0] model_pc;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] w;
    w = {2'b00, a[31:2]};
    return 32'h00000013 + w * 32'h00500080;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference stream: after reset or a redirect the core must see consecutive words from the start PC.
  task automatic topup();
    while (exp_q.size() < 8) begin
      exp_q.push_back({mem_word(model_pc), model_pc});
      model_pc = model_pc + 64'd4;
    end
  endtask

  task automatic sb_restart(input logic [63:0] pc);
    exp_q.delete();
    model_pc = pc & ~64'd3;
    topup();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    topup();
  endtask

  task automatic apply_reset();
    #2;
    reset = 1'b0;
    epoch++;
    bus.redirect = 1'b0;
    sb_restart(RESET_PC);
    #1;
    check("rst_req", bus.imem_req, 0);
    check("rst_addr", bus.imem_addr, RESET_PC);
    check("rst_valid", bus.inst_valid, 0);
    check("rst_inst", bus.inst, 0);
    check("rst_inst_pc", bus.inst_pc, 0);
    repeat (2) tick();
    reset = 1'b1;
  endtask

  // Memory: ack after lat cycles of a request; also checks request stability until ack.
  initial begin
    logic        ack_was;
    logic        prev_pending;
    logic [63:0] prev_addr;
    int          prev_epoch;
    int          cnt;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    cnt = 0;
    prev_pending = 1'b0;
    prev_addr = '0;
    prev_epoch = 0;
    forever begin
      @(posedge clk);
      ack_was = bus.imem_ack;
      #1;
      if (prev_pending && reset && prev_epoch == epoch) begin
        check("req_held", bus.imem_req, 1);
        check("addr_held", bus.imem_addr, prev_addr);
      end
      if (!bus.imem_req) cnt = 0;
      else if (ack_was) cnt = 1;
      else cnt = cnt + 1;
      if (bus.imem_req && cnt >= lat) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_word(bus.imem_addr);
        ack_cnt++;
      end else begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
      end
      prev_pending = bus.imem_req && !bus.imem_ack;
      prev_addr    = bus.imem_addr;
      prev_epoch   = epoch;
    end
  end

  // Monitor: every accepted instruction is popped from the scoreboard and compared.
  initial begin
    logic [95:0] e;
    forever begin
      @(negedge clk);
      if (reset && bus.inst_valid && bus.inst_ready && !bus.redirect) begin
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL sb_empty: got pc %h expected a queued entry", bus.inst_pc);
        end else begin
          e = exp_q.pop_front();
          check("inst_pc", bus.inst_pc, e[63:0]);
          check("inst", {32'h0, bus.inst}, {32'h0, e[95:64]});
        end
        delivered++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a0;
    int d0;
    bit found;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.inst_ready  = 1'b1;
    sb_restart(RESET_PC);
    tick();

    // Streaming with a single-cycle memory.
    lat = 1;
    bus.inst_ready = 1'b1;
    apply_reset();
    @(negedge clk);
    check("c0_req", bus.imem_req, 0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      @(negedge clk);
      check("stream_req", bus.imem_req, 1);
      check("stream_addr", bus.imem_addr, 64'(4 * (k - 1)));
      if (BYP) begin
        check("stream_valid", bus.inst_valid, 1);
        check("stream_pc", bus.inst_pc, 64'(4 * (k - 1)));
      end else begin
        check("stream_valid", bus.inst_valid, (k >= 2) ? 1 : 0);
        if (k >= 2) check("stream_pc", bus.inst_pc, 64'(4 * (k - 2)));
      end
    end

    // Core stalled: fill exactly DEPTH entries, then resume.
    bus.inst_ready = 1'b0;
    apply_reset();
    @(negedge clk);
    a0 = ack_cnt;
    repeat (12) tick();
    @(negedge clk);
    check("stall_pushes", 64'(ack_cnt - a0), 64'(DEPTH));
    check("stall_req", bus.imem_req, 0);
    tick();
    bus.inst_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      @(negedge clk);
      if (bus.imem_req) found = 1'b1;
    end
    check("resume_found", found, 1);
    check("resume_addr", bus.imem_addr, 64'h10);
    repeat (8) tick();

    // Redirect while a slow request is outstanding.
    lat = 3;
    apply_reset();
    tick();
    @(negedge clk);
    check("slow_req", bus.imem_req, 1);
    check("slow_addr", bus.imem_addr, 64'h0);
    tick();
    bus.redirect = 1'b1;
    bus.redirect_pc = 64'h103;
    sb_restart(64'h103);
    tick();
    bus.redirect = 1'b0;
    @(negedge clk);
    check("disc_req", bus.imem_req, 1);
    check("disc_addr", bus.imem_addr, 64'h0);
    check("disc_valid", bus.inst_valid, 0);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      tick();
      @(negedge clk);
      if (bus.imem_req && bus.imem_addr != 64'h0) found = 1'b1;
    end
    check("redir_found", found, 1);
    check("redir_addr", bus.imem_addr, 64'h100);
    d0 = delivered;
    repeat (12) tick();
    check("redir_progress", (delivered > d0) ? 1 : 0, 1);

    // Redirect in the same cycle as a kept ack with a pop pending.
    lat = 1;
    repeat (6) tick();
    bus.redirect = 1'b1;
    bus.redirect_pc = 64'h40;
    sb_restart(64'h40);
    @(negedge clk);
    check("rwa_valid", bus.inst_valid, 1);
    check("rwa_ack", bus.imem_ack, 1);
    tick();
    bus.redirect = 1'b0;
    @(negedge clk);
    check("rwa_req", bus.imem_req, 1);
    check("rwa_addr", bus.imem_addr, 64'h40);
    check("rwa_valid_next", bus.inst_valid, BYP ? 1 : 0);
    if (BYP) begin
      check("byp_pc", bus.inst_pc, 64'h40);
      check("byp_inst", {32'h0, bus.inst}, {32'h0, mem_word(64'h40)});
    end
    repeat (6) tick();

    // Asynchronous reset in the middle of a request.
    lat = 3;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      if (bus.imem_req && !bus.imem_ack) found = 1'b1;
    end
    check("midwait_found", found, 1);
    apply_reset();
    tick();
    @(negedge clk);
    check("rerun_req", bus.imem_req, 1);
    check("rerun_addr", bus.imem_addr, RESET_PC);

    // Randomized run.
    d0 = delivered;
    for (int i = 0; i < 3000; i++) begin
      tick();
      bus.inst_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 99) == 0) lat = $urandom_range(1, 3);
      if (i == 2000) begin
        apply_reset();
      end else if (i == 1500 || $urandom_range(0, 49) == 0) begin
        bus.redirect = 1'b1;
        bus.redirect_pc = (i == 1500) ? 64'hFFFF_FFFF_FFFF_FFF3 : {$urandom, $urandom};
        sb_restart(bus.redirect_pc);
      end else begin
        bus.redirect = 1'b0;
      end
    end
    tick();
    bus.redirect = 1'b0;
    repeat (4) tick();
    check("random_progress", (delivered - d0 > 300) ? 1 : 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
